// File: rtl/arb_client_port_pkg.sv
// Shared definitions for the arbitrated client port.
//   - Default channel count, payload width and per-channel buffer depth.
//   - Output-slot state encoding.
//   - Pointer-width helper used by the channel FIFO.
package arb_client_port_pkg;

   localparam int unsigned ARB_N_DEF     = 3;
   localparam int unsigned ARB_WIDTH_DEF = 8;
   localparam int unsigned ARB_DEPTH_DEF = 2;

   typedef enum logic {
      SLOT_EMPTY  = 1'b0,
      SLOT_LOADED = 1'b1
   } slot_state_e;

   // A pointer needs at least one bit even when DEPTH is 1.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/arb_client_port_chan_fifo.sv
// chan_fifo: single-channel FIFO of DEPTH entries.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write request and payload (ignored when full)
//   pop, pop_data   : read request (ignored when empty) and current head
//   count           : occupancy 0..DEPTH
//   full, empty     : occupancy flags
// Storage contents are not cleared by reset; only pointers and count are.
module chan_fifo
   import arb_client_port_pkg::*;
#(
   parameter int unsigned WIDTH = ARB_WIDTH_DEF,
   parameter int unsigned DEPTH = ARB_DEPTH_DEF,
   localparam int unsigned CW   = $clog2(DEPTH + 1),
   localparam int unsigned PW   = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // Fullness is judged on the registered count, so a pop in the same
   // cycle never frees space for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/arb_client_port.sv
// arb_client_port: N buffered client channels feeding a shared output slot
// through an external round-robin arbiter.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_data    : per-channel upstream payloads (channel i at [i*WIDTH +: WIDTH])
//   in_ready            : per-channel space available
//   req                 : per-channel non-empty request to the arbiter
//   gnt                 : arbiter grant, one-hot or zero
//   out_valid/out_data  : shared-bus payload
//   out_src             : one-hot source channel of out_data
//   out_ready           : shared-bus consumer ready
//   err                 : sticky flag for malformed or unrequested grants
module arb_client_port
   import arb_client_port_pkg::*;
#(
   parameter int unsigned N     = ARB_N_DEF,
   parameter int unsigned WIDTH = ARB_WIDTH_DEF,
   parameter int unsigned DEPTH = ARB_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic [N-1:0]       req,
   input  logic [N-1:0]       gnt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [N-1:0]       out_src,
   input  logic               out_ready,
   output logic               err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    fifo_count [N];
   logic [WIDTH-1:0] fifo_head  [N];
   logic [N-1:0]     fifo_full;
   logic [N-1:0]     fifo_empty;
   logic [N-1:0]     fifo_push;
   logic [N-1:0]     fifo_pop;

   logic             gnt_onehot;
   logic             gnt_legal;
   logic             gnt_illegal;
   logic             accept;
   logic             load;
   logic [WIDTH-1:0] head_sel;

   slot_state_e      state_q;
   slot_state_e      state_d;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         assign in_ready[gi]  = (fifo_count[gi] < CW'(DEPTH));
         assign req[gi]       = !fifo_empty[gi];
         assign fifo_push[gi] = in_valid[gi] && !fifo_full[gi];

         chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[gi]),
            .push_data (in_data[gi*WIDTH +: WIDTH]),
            .pop       (fifo_pop[gi]),
            .pop_data  (fifo_head[gi]),
            .count     (fifo_count[gi]),
            .full      (fifo_full[gi]),
            .empty     (fifo_empty[gi])
         );
      end
   endgenerate

   // Legal grant: exactly one bit set, and that channel is requesting.
   assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - 1'b1)) == '0);
   assign gnt_legal   = gnt_onehot && ((gnt & req) == gnt);
   assign gnt_illegal = (gnt != '0) && !gnt_legal;

   assign out_valid = (state_q == SLOT_LOADED);
   assign accept    = gnt_legal && (!out_valid || out_ready);
   assign fifo_pop  = accept ? gnt : '0;

   always_comb begin
      head_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) head_sel |= fifo_head[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= SLOT_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         SLOT_EMPTY: begin
            if (accept) begin
               load    = 1'b1;
               state_d = SLOT_LOADED;
            end
         end
         SLOT_LOADED: begin
            if (out_ready) begin
               if (accept) load    = 1'b1;
               else        state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data <= '0;
         out_src  <= '0;
      end else if (load) begin
         out_data <= head_sel;
         out_src  <= gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)            err <= 1'b0;
      else if (gnt_illegal) err <= 1'b1;
   end

endmodule

// File: doc/arb_client_port.md
ARB_CLIENT_PORT -- requirements
Module: arb_client_port

Interface
REQ-001 Parameter N, default 3, number of client channels (one per arbiter request line).
REQ-002 Parameter WIDTH, default 8, payload width in bits.
REQ-003 Parameter DEPTH, default 2, per-channel buffer depth in entries (DEPTH >= 1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  N  per-channel upstream payload valid.
REQ-007 in_data  input  N*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel upstream ready.
REQ-009 req  output  N  request lines to the round-robin arbiter.
REQ-010 gnt  input  N  grant from the arbiter, expected one-hot or zero.
REQ-011 out_valid  output  1  shared-bus payload valid.
REQ-012 out_data  output  WIDTH  shared-bus payload.
REQ-013 out_src  output  N  one-hot tag of channel that produced out_data.
REQ-014 out_ready  input  1  shared-bus consumer ready.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Each channel SHALL own an independent FIFO of DEPTH entries with occupancy count 0..DEPTH and wrap-around read/write pointers.
REQ-017 in_ready[i] SHALL equal (count[i] < DEPTH), combinational from registered count; a push when full is never accepted, even on a simultaneous pop.
REQ-018 Push on channel i SHALL occur at an edge where in_valid[i] && in_ready[i]; entries leave in arrival order.
REQ-019 req[i] SHALL equal (count[i] != 0); a push at edge t raises req[i] in the cycle after t.
REQ-020 A grant SHALL be legal when gnt is exactly one-hot, gnt[i] && req[i].
REQ-021 A grant SHALL be accepted when legal and the output slot is free or draining (!out_valid || out_ready).
REQ-022 On accepted grant at edge t, channel i SHALL pop its head; out_valid=1, out_data=head, out_src=gnt from cycle t+1.
REQ-023 Output slot states: EMPTY (out_valid=0) and LOADED (out_valid=1); EMPTY->LOADED on accept; LOADED->EMPTY on out_ready without accept; LOADED->LOADED on out_ready with accept (back-to-back, new payload); LOADED held unchanged while out_ready=0.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_src SHALL remain stable and legal grants SHALL be ignored (no pop).
REQ-025 Simultaneous push and accepted pop on one channel SHALL leave count unchanged and both pointers advance.
REQ-026 An illegal grant (gnt with more than one bit set, or gnt[i] with req[i]=0) SHALL cause no pop and SHALL set err at the next edge.
REQ-027 err SHALL remain 1 until reset.
REQ-028 gnt=0 SHALL be legal and cause no action.
REQ-029 Sustained throughput SHALL be one payload per cycle when out_ready=1 and legal grants arrive every cycle.

Reset
REQ-030 When reset=1 at an edge: all counts and pointers cleared, out_valid=0, out_data=0, out_src=0, err=0; hence req=0 and in_ready=all ones in the following cycle.
REQ-031 Reset mid-operation SHALL discard all buffered and in-flight payloads; pushes, pops and grants at a reset edge are ignored.
REQ-032 FIFO storage contents need not be cleared.

Structure
REQ-033 Defaults for N, WIDTH, DEPTH and the output-slot state encoding SHALL live in the shared package.
REQ-034 Per-channel buffering SHALL be one sub-module, chan_fifo (push, pop, data, count, full/empty), instantiated N times.
REQ-035 Count width SHALL be clog2(DEPTH+1); pointer width max(1, clog2(DEPTH)).

Verification
REQ-036 Push 0x5A on ch0, gnt=001 next cycle, out_ready=1 -> req=001 one cycle after push; out_valid=1, out_data=0x5A, out_src=001 the cycle after grant; req=000 afterwards.
REQ-037 Push 0x11,0x22 on ch1 (DEPTH=2), third push 0x33 held -> in_ready[1]=0 until a pop; grants yield 0x11 then 0x22 in order.
REQ-038 One entry each on ch0..ch2, gnt cycling 001,010,100 with out_ready=1 -> three consecutive out_valid cycles, out_src 001,010,100.
REQ-039 out_valid=1, out_ready=0 for 4 cycles with gnt=010 and req=010 -> out_data stable, ch1 count unchanged, no err.
REQ-040 gnt=011, then gnt=100 with req[2]=0 -> err=1 next cycle, no counts change, err stays 1 until reset.
REQ-041 Reset asserted with two entries buffered and out_valid=1 -> next cycle out_valid=0, req=000, in_ready=111, err=0.
